fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

- Input frame sequencer for the R2²SDF FFT pipeline.
- Buffers complex samples from a valid/ready source and releases them to the pipeline only as gap-free N-sample bursts on `idata_en`. The SDF butterfly phase resets whenever the enable drops, so every frame must arrive contiguously.
- Also tracks the pipeline output enable: it marks frame start and end, and flags any broken output frame.

## Interface
Parameters:
- WIDTH, 16, sample component width (real and imag)
- LOG_N, 6, log2 of FFT length; N = 2^LOG_N
- GAP, 1, minimum idle cycles between frames, legal range 0..15

Ports:
- clock  in  1  master clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort/clear
- s_valid  in  1  source sample valid
- s_ready  out  1  controller can accept a sample
- s_data_r  in  WIDTH  source sample, real
- s_data_i  in  WIDTH  source sample, imag
- fft_en  out  1  to pipeline `idata_en`, registered
- fft_r  out  WIDTH  to pipeline `idata_r`, registered
- fft_i  out  WIDTH  to pipeline `idata_i`, registered
- fft_oen  in  1  pipeline `odata_en`
- frame_start  out  1  first output sample of a frame
- frame_last  out  1  last output sample of a frame
- err_break  out  1  sticky: output frame interrupted

## Operation
Input side:
- FIFO depth is 2N entries; occupancy counter `occ` is 0..2N.
- `s_ready = !full && !flush`.
- A push occurs on a cycle where s_valid and s_ready are both high.
- A push and a pop in the same cycle leave occ unchanged.
- Data ordering is strict FIFO.

Sequencer FSM, states IDLE, FEED, GAP:
- IDLE: if occ ≥ N, go to FEED and clear the sample counter `scnt`.
- FEED: pop one entry every cycle and increment scnt.
  - At scnt == N-1 with GAP > 0: go to GAP.
  - At scnt == N-1 with GAP == 0: stay in FEED with scnt = 0 if post-pop occ ≥ N, otherwise go to IDLE.
- GAP: count GAP cycles, then go to IDLE.
- A frame is never started without N entries present, so FEED never underflows.

Output tracker:
- `ocnt` (LOG_N bits) increments on each fft_oen and wraps to 0 after N-1.
- `frame_start = fft_oen && ocnt == 0` (combinational from registered ocnt).
- `frame_last = fft_oen && ocnt == N-1`.
- err_break sets when fft_oen is low while ocnt != 0. It holds until reset or flush.

Flush, one cycle, valid in any state:
- Empties the FIFO and forces the FSM to IDLE.
- Clears scnt, ocnt and err_break.
- fft_en is low from the next edge onward.
- A push attempted in the flush cycle is dropped (s_ready is low).

Reset values:
- FIFO empty, FSM in IDLE.
- fft_en 0, fft_r/fft_i 0, err_break 0.
- frame_start/frame_last 0. s_ready 1 once reset releases.

## Timing
- fft_en, fft_r and fft_i are registered copies of the pop strobe and FIFO head. They appear one cycle after the FEED cycle that popped them.
- Latency: the Nth sample is accepted at edge e; the FSM enters FEED at e+1; fft_en first goes high at e+2.
- During a frame, fft_en stays high for exactly N consecutive cycles.
- Between frames, fft_en stays low for at least GAP+1 cycles when GAP > 0. With GAP = 0 and data available, frames are back-to-back.
- FIFO full: s_ready drops in the same cycle that occ reaches 2N. A pop in that cycle does not raise s_ready until the next cycle, because s_ready derives from registered occ.
- Asserting reset mid-frame truncates fft_en immediately (asynchronous). The pipeline's own reset covers its state.

## Structure
- Shared package `fft_ctrl_pkg` holds:
  - FSM state encoding (IDLE=0, FEED=1, GAP=2)
  - a clog2 helper
  - localparams N and FIFO_DEPTH = 2N
- One sub-module, `frame_fifo`: synchronous FIFO with parameters WIDTH×2 and DEPTH. It provides push, pop, head, occ, full and empty.
- The FIFO uses an inferred RAM with registered pointers and no output register. The registered fft data outputs reside in fft_frame_ctrl.
- The FSM, scnt, GAP counter and output tracker are implemented in fft_frame_ctrl.

## Test plan
All cases use LOG_N=2 (N=4), GAP=1.
- Continuous input: push 8 samples (1..8) on consecutive cycles with s_valid held high.
  - fft_en high for 4 cycles carrying 1,2,3,4, then low for ≥2 cycles, then high for 4 cycles carrying 5,6,7,8.
  - First fft_en occurs 2 cycles after the 4th push.
- Partial frame: push 3 samples.
  - fft_en stays 0 indefinitely.
  - A 4th push starts the frame 2 cycles later.
- Full and backpressure: hold the FSM out of FEED by pushing 8 samples with no pop opportunity (pipeline outputs ignored).
  - s_ready falls after the 8th push.
  - A 9th sample held valid is accepted only after FEED frees space; no data is lost or duplicated.
- Output marks: drive fft_oen high for 8 consecutive cycles.
  - frame_start pulses on cycles 1 and 5.
  - frame_last pulses on cycles 4 and 8.
  - err_break stays 0.
- Broken output frame: fft_oen high 2 cycles, low 1 cycle.
  - err_break goes to 1 and stays set.
  - A subsequent flush clears it and ocnt restarts, so the next fft_oen gives frame_start.
- Flush mid-FEED: after 2 of 4 samples appear on fft_en, pulse flush.
  - fft_en is 0 from the next cycle and the FIFO is empty.
  - A push in the flush cycle is dropped.
  - Four new pushes produce a clean frame with the new values.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT input frame sequencer: state encoding,
// a constant-width helper and the default frame geometry.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;

  // Smallest w such that 2**w >= value; used to size pointers and counters.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int DEF_LOG_N  = 6;
  localparam int N          = 1 << DEF_LOG_N;
  localparam int FIFO_DEPTH = 2 * N;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous FIFO holding packed {real, imag} samples. The head entry is read
// straight from the RAM (no output register); the caller registers it.
module frame_fifo
  import fft_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_flush,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_head,
  output logic [clog2(DEPTH+1)-1:0]   o_occ,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int OW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [OW-1:0]    r_occ;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPush = i_push && !i_flush;
  assign w_doPop  = i_pop && !i_flush;

  // Sample storage; left without reset so it maps onto plain RAM.
  always_ff @(posedge i_clock) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers and occupancy; flush drops every stored entry at once.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_occ   <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_occ   <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_occ   = r_occ;
  assign o_full  = (r_occ == OW'(DEPTH));
  assign o_empty = (r_occ == '0);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Input frame sequencer for the R2^2 SDF FFT: buffers source samples and
// releases them only as contiguous N-sample bursts, and tracks output framing.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LOG_N = DEF_LOG_N,
  parameter int GAP   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data_r,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             fft_en,
  output logic [WIDTH-1:0] fft_r,
  output logic [WIDTH-1:0] fft_i,
  input  logic             fft_oen,
  output logic             frame_start,
  output logic             frame_last,
  output logic             err_break
);

  localparam int FRAME_N = 1 << LOG_N;
  localparam int DEPTH   = 2 * FRAME_N;
  localparam int OCC_W   = clog2(DEPTH + 1);
  localparam bit HAS_GAP = (GAP > 0);

  seq_state_t         r_state;
  logic [LOG_N-1:0]   r_scnt;
  logic [3:0]         r_gcnt;
  logic               r_fftEn;
  logic [WIDTH-1:0]   r_fftR;
  logic [WIDTH-1:0]   r_fftI;
  logic [LOG_N-1:0]   r_ocnt;
  logic               r_errBreak;

  logic               w_push;
  logic               w_pop;
  logic [2*WIDTH-1:0] w_head;
  logic [OCC_W-1:0]   w_occ;
  logic               w_full;
  logic               w_empty;
  logic               w_frameReady;

  assign s_ready      = !w_full && !flush;
  assign w_push       = s_valid && s_ready;
  assign w_pop        = (r_state == ST_FEED) && !flush && !w_empty;
  assign w_frameReady = (w_occ >= OCC_W'(FRAME_N));

  frame_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clock (clock),
    .i_reset (reset),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  ({s_data_r, s_data_i}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_occ   (w_occ),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Frame sequencer plus the registered pipeline feed it drives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_scnt  <= '0;
      r_gcnt  <= '0;
      r_fftEn <= 1'b0;
      r_fftR  <= '0;
      r_fftI  <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_scnt  <= '0;
      r_gcnt  <= '0;
      r_fftEn <= 1'b0;
    end else begin
      r_fftEn <= w_pop;
      if (w_pop) begin
        r_fftR <= w_head[2*WIDTH-1:WIDTH];
        r_fftI <= w_head[WIDTH-1:0];
      end
      case (r_state)
        ST_IDLE: begin
          if (w_frameReady) begin
            r_state <= ST_FEED;
            r_scnt  <= '0;
          end
        end
        ST_FEED: begin
          if (r_scnt == LOG_N'(FRAME_N - 1)) begin
            r_scnt <= '0;
            if (HAS_GAP) begin
              r_state <= ST_GAP;
              r_gcnt  <= '0;
            end else if (w_occ > OCC_W'(FRAME_N)) begin
              r_state <= ST_FEED;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_scnt <= r_scnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gcnt == 4'(GAP - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output frame tracker: position within the frame and sticky break flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ocnt     <= '0;
      r_errBreak <= 1'b0;
    end else if (flush) begin
      r_ocnt     <= '0;
      r_errBreak <= 1'b0;
    end else if (fft_oen) begin
      r_ocnt <= r_ocnt + 1'b1;
    end else if (r_ocnt != '0) begin
      r_errBreak <= 1'b1;
    end
  end

  assign fft_en      = r_fftEn;
  assign fft_r       = r_fftR;
  assign fft_i       = r_fftI;
  assign frame_start = fft_oen && (r_ocnt == '0);
  assign frame_last  = fft_oen && (r_ocnt == '1);
  assign err_break   = r_errBreak;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl with N=4, GAP=1.
module tb_fft_frame_ctrl;

  localparam int WIDTH = 16;
  localparam int LOG_N = 2;
  localparam int GAP   = 1;
  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data_r;
  logic [WIDTH-1:0] s_data_i;
  logic             fft_en;
  logic [WIDTH-1:0] fft_r;
  logic [WIDTH-1:0] fft_i;
  logic             fft_oen;
  logic             frame_start;
  logic             frame_last;
  logic             err_break;

  int checksTotal = 0;
  int checksPassed = 0;

  logic [31:0] expQ[$];
  int          riseQ[$];
  int          cycleCnt = 0;
  int          enCount = 0;
  int          frameCount = 0;
  int          runLen = 0;
  int          gapLen = 0;
  int          occModel = 0;
  int          readyLowCycles = 0;
  bit          prevEn = 0;
  bit          truncOk = 0;
  bit          sawFrame = 0;
  bit          pendingPush = 0;

  fft_frame_ctrl #(
    .WIDTH (WIDTH),
    .LOG_N (LOG_N),
    .GAP   (GAP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data_r    (s_data_r),
    .s_data_i    (s_data_i),
    .fft_en      (fft_en),
    .fft_r       (fft_r),
    .fft_i       (fft_i),
    .fft_oen     (fft_oen),
    .frame_start (frame_start),
    .frame_last  (frame_last),
    .err_break   (err_break)
  );

  // Free-running clock and an edge counter used to time latencies.
  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Scoreboard monitor: models occupancy to predict s_ready, queues accepted
  // samples, and on every fft_en beat pops and compares the expected sample.
  // It also checks each burst is exactly N long and the idle gap is long enough.
  always @(negedge clock) begin
    logic [31:0] expWord;
    if (reset) begin
      expQ.delete();
      occModel    = 0;
      pendingPush = 0;
      prevEn      = 0;
      runLen      = 0;
      gapLen      = 0;
      sawFrame    = 0;
      truncOk     = 0;
    end else begin
      if (pendingPush) occModel++;
      if (fft_en) occModel--;
      checksTotal++;
      if (s_ready !== ((occModel < DEPTH) && !flush))
        $display("[TB] FAIL s_ready_model: got %b expected %b (occ %0d)", s_ready, (occModel < DEPTH) && !flush, occModel);
      else
        checksPassed++;
      pendingPush = s_valid && s_ready;
      if (s_valid && s_ready) expQ.push_back({s_data_r, s_data_i});
      if (!s_ready && !flush) readyLowCycles++;

      if (fft_en) begin
        enCount++;
        if (!prevEn) begin
          riseQ.push_back(cycleCnt);
          if (sawFrame) begin
            checksTotal++;
            if (gapLen < GAP + 1)
              $display("[TB] FAIL frame_gap: got %0d idle cycles expected at least %0d", gapLen, GAP + 1);
            else
              checksPassed++;
          end
        end
        runLen++;
        checksTotal++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL unexpected_fft_en: got data %h expected no output", {fft_r, fft_i});
        end else begin
          expWord = expQ.pop_front();
          if ({fft_r, fft_i} !== expWord)
            $display("[TB] FAIL fft_data: got %h expected %h", {fft_r, fft_i}, expWord);
          else
            checksPassed++;
        end
      end else begin
        if (prevEn) begin
          if (!truncOk) begin
            checksTotal++;
            if (runLen != N)
              $display("[TB] FAIL burst_length: got %0d expected %0d", runLen, N);
            else
              checksPassed++;
          end
          if (runLen == N) frameCount++;
          sawFrame = 1;
          truncOk  = 0;
          runLen   = 0;
          gapLen   = 0;
        end
        gapLen++;
      end

      if (flush) begin
        expQ.delete();
        occModel    = 0;
        pendingPush = 0;
        sawFrame    = 0;
        if (fft_en || runLen > 0) truncOk = 1;
      end
      prevEn = fft_en;
    end
  end

  // Safety net so the run always ends even if the design wedges.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic pushSample(input logic [15:0] re, input logic [15:0] im, output int pushEdge);
    bit accepted;
    int waited;
    accepted = 0;
    waited   = 0;
    pushEdge = -1;
    s_valid  = 1'b1;
    s_data_r = re;
    s_data_i = im;
    while (!accepted && waited < 100) begin
      @(negedge clock);
      if (s_ready) begin
        accepted = 1;
        pushEdge = cycleCnt + 1;
      end
      @(posedge clock);
      #1;
      waited++;
    end
    s_valid = 1'b0;
    checksTotal++;
    if (!accepted)
      $display("[TB] FAIL push_timeout: got no acceptance expected acceptance of %h", {re, im});
    else
      checksPassed++;
  endtask

  task automatic drainFrames();
    int waited;
    waited = 0;
    while ((expQ.size() != 0 || fft_en) && waited < 300) begin
      @(posedge clock);
      #1;
      waited++;
    end
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    checksTotal++;
    if (expQ.size() != 0)
      $display("[TB] FAIL drain_timeout: got %0d pending samples expected 0", expQ.size());
    else
      checksPassed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checksTotal++;
    if (fft_en !== 1'b0) $display("[TB] FAIL reset_fft_en: got %b expected 0", fft_en);
    else checksPassed++;
    checksTotal++;
    if (err_break !== 1'b0) $display("[TB] FAIL reset_err_break: got %b expected 0", err_break);
    else checksPassed++;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checksTotal++;
    if (s_ready !== 1'b1) $display("[TB] FAIL reset_s_ready: got %b expected 1", s_ready);
    else checksPassed++;
    checksTotal++;
    if ({fft_r, fft_i} !== 32'h0) $display("[TB] FAIL reset_fft_data: got %h expected 0", {fft_r, fft_i});
    else checksPassed++;
    checksTotal++;
    if ({frame_start, frame_last} !== 2'b00)
      $display("[TB] FAIL reset_marks: got %b expected 00", {frame_start, frame_last});
    else checksPassed++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_continuous();
    int pe;
    int pe4;
    int f0;
    f0  = frameCount;
    pe4 = -1;
    riseQ.delete();
    for (int k = 1; k <= 8; k++) begin
      pushSample(16'(k), 16'(k + 256), pe);
      if (k == 4) pe4 = pe;
    end
    drainFrames();
    checksTotal++;
    if (frameCount - f0 != 2) $display("[TB] FAIL cont_frames: got %0d expected 2", frameCount - f0);
    else checksPassed++;
    checksTotal++;
    if (riseQ.size() != 2) $display("[TB] FAIL cont_bursts: got %0d expected 2", riseQ.size());
    else checksPassed++;
    if (riseQ.size() >= 2) begin
      checksTotal++;
      if (riseQ[0] - pe4 != 2)
        $display("[TB] FAIL cont_latency: got %0d edges expected 2", riseQ[0] - pe4);
      else checksPassed++;
      checksTotal++;
      if (riseQ[1] - riseQ[0] < N + GAP + 1)
        $display("[TB] FAIL cont_spacing: got %0d edges expected at least %0d", riseQ[1] - riseQ[0], N + GAP + 1);
      else checksPassed++;
    end
  endtask

  task automatic test_partial();
    int pe;
    riseQ.delete();
    for (int k = 0; k < 3; k++) pushSample(16'(11 + k), 16'(511 - k), pe);
    repeat (20) begin
      @(posedge clock);
      #1;
    end
    checksTotal++;
    if (riseQ.size() != 0) $display("[TB] FAIL partial_idle: got %0d bursts expected 0", riseQ.size());
    else checksPassed++;
    pushSample(16'd14, 16'd508, pe);
    drainFrames();
    checksTotal++;
    if (riseQ.size() != 1 || riseQ[0] - pe != 2)
      $display("[TB] FAIL partial_start: got %0d bursts, latency %0d expected 1 burst, latency 2",
               riseQ.size(), (riseQ.size() > 0) ? riseQ[0] - pe : -1);
    else checksPassed++;
  endtask

  task automatic test_backpressure();
    int pe;
    int e0;
    e0 = enCount;
    readyLowCycles = 0;
    for (int k = 0; k < 40; k++) pushSample(16'(1000 + k), 16'(2000 + 3 * k), pe);
    drainFrames();
    checksTotal++;
    if (readyLowCycles == 0) $display("[TB] FAIL bp_full: got 0 stalled cycles expected at least 1");
    else checksPassed++;
    checksTotal++;
    if (enCount - e0 != 40) $display("[TB] FAIL bp_count: got %0d samples expected 40", enCount - e0);
    else checksPassed++;
  endtask

  task automatic test_output_marks();
    for (int i = 0; i < 8; i++) begin
      fft_oen = 1'b1;
      @(negedge clock);
      checksTotal++;
      if (frame_start !== ((i == 0) || (i == 4)))
        $display("[TB] FAIL mark_start_%0d: got %b expected %b", i, frame_start, (i == 0) || (i == 4));
      else checksPassed++;
      checksTotal++;
      if (frame_last !== ((i == 3) || (i == 7)))
        $display("[TB] FAIL mark_last_%0d: got %b expected %b", i, frame_last, (i == 3) || (i == 7));
      else checksPassed++;
      @(posedge clock);
      #1;
    end
    fft_oen = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checksTotal++;
    if (err_break !== 1'b0) $display("[TB] FAIL mark_err: got %b expected 0", err_break);
    else checksPassed++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_broken_frame();
    fft_oen = 1'b1;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    fft_oen = 1'b0;
    @(negedge clock);
    checksTotal++;
    if (err_break !== 1'b0) $display("[TB] FAIL break_early: got %b expected 0", err_break);
    else checksPassed++;
    @(negedge clock);
    checksTotal++;
    if (err_break !== 1'b1) $display("[TB] FAIL break_set: got %b expected 1", err_break);
    else checksPassed++;
    repeat (3) @(negedge clock);
    checksTotal++;
    if (err_break !== 1'b1) $display("[TB] FAIL break_sticky: got %b expected 1", err_break);
    else checksPassed++;
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush   = 1'b0;
    fft_oen = 1'b1;
    @(negedge clock);
    checksTotal++;
    if (err_break !== 1'b0) $display("[TB] FAIL break_clear: got %b expected 0", err_break);
    else checksPassed++;
    checksTotal++;
    if (frame_start !== 1'b1) $display("[TB] FAIL break_restart: got %b expected 1", frame_start);
    else checksPassed++;
    @(posedge clock);
    #1;
    fft_oen = 1'b0;
    flush   = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
  endtask

  task automatic test_flush_mid_feed();
    int pe;
    int e0;
    int f0;
    int waited;
    e0 = enCount;
    for (int k = 0; k < 4; k++) pushSample(16'(21 + k), 16'(0 - k), pe);
    waited = 0;
    while (enCount - e0 < 2 && waited < 50) begin
      @(posedge clock);
      #1;
      waited++;
    end
    checksTotal++;
    if (enCount - e0 != 2) $display("[TB] FAIL flush_setup: got %0d samples expected 2", enCount - e0);
    else checksPassed++;
    flush    = 1'b1;
    s_valid  = 1'b1;
    s_data_r = 16'd99;
    s_data_i = 16'd99;
    @(negedge clock);
    checksTotal++;
    if (s_ready !== 1'b0) $display("[TB] FAIL flush_s_ready: got %b expected 0", s_ready);
    else checksPassed++;
    @(posedge clock);
    #1;
    flush   = 1'b0;
    s_valid = 1'b0;
    @(negedge clock);
    checksTotal++;
    if (fft_en !== 1'b0) $display("[TB] FAIL flush_fft_en: got %b expected 0", fft_en);
    else checksPassed++;
    @(posedge clock);
    #1;
    e0 = enCount;
    f0 = frameCount;
    for (int k = 0; k < 3; k++) pushSample(16'(31 + k), 16'(77 + k), pe);
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    checksTotal++;
    if (enCount != e0) $display("[TB] FAIL flush_empty: got %0d samples expected 0", enCount - e0);
    else checksPassed++;
    pushSample(16'd34, 16'd80, pe);
    drainFrames();
    checksTotal++;
    if (frameCount - f0 != 1 || enCount - e0 != 4)
      $display("[TB] FAIL flush_refill: got %0d frames %0d samples expected 1 frame 4 samples",
               frameCount - f0, enCount - e0);
    else checksPassed++;
  endtask

  // Test sequence: each scenario drives its own stimulus and checks inline.
  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    s_valid  = 1'b0;
    s_data_r = '0;
    s_data_i = '0;
    fft_oen  = 1'b0;
    test_reset();
    test_continuous();
    test_partial();
    test_backpressure();
    test_output_marks();
    test_broken_frame();
    test_flush_mid_feed();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
